// File: rtl/sad_pe_array.sv
// Motion-estimation SAD engine: 16 staggered PEs accumulate |ref - search| over NPIX pixels
// per pass and present each PE's result once, with a one-hot ready and its (x, y) vector.
module sad_pe_array #(
  parameter int NPIX  = 16,
  parameter int NPASS = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [7:0]   r_pix,
  input  logic [127:0] s_pix,
  output logic [127:0] peout,
  output logic [15:0]  peready,
  output logic [3:0]   vectorx,
  output logic [3:0]   vectory,
  output logic         compstart,
  output logic         busy,
  output logic         done
);

  localparam int         NPE   = 16;
  localparam logic [7:0] TLAST = 8'(NPIX + NPE - 1);
  localparam logic [7:0] NPIX8 = 8'(NPIX);
  localparam logic [3:0] PLAST = 4'(NPASS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e         state_q, state_d;
  logic [7:0]     t_q, t_d;
  logic [3:0]     pass_q, pass_d;
  logic [7:0]     rdly_q [1:NPE-1];
  logic [NPE-1:0] fin;
  logic [15:0]    peready_q;
  logic [3:0]     vx_q, vx_d, vy_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      t_q     <= '0;
      pass_q  <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          t_d     = '0;
          pass_d  = '0;
        end
      end
      RUN: begin
        if (t_q == TLAST) begin
          t_d = '0;
          if (pass_q == PLAST) state_d = DONE;
          else                 pass_d  = pass_q + 4'd1;
        end else begin
          t_d = t_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Tap j carries the reference pixel seen j cycles ago, so PE j lines up with its stagger.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int j = 1; j < NPE; j++) rdly_q[j] <= '0;
    end else begin
      rdly_q[1] <= r_pix;
      for (int j = 2; j < NPE; j++) rdly_q[j] <= rdly_q[j-1];
    end
  end

  for (genvar i = 0; i < NPE; i++) begin : g_pe
    logic [7:0] ref_px, srch_px, diff, offs, sum;
    logic [8:0] add;
    logic       active;
    logic [7:0] acc_q, res_q;

    if (i == 0) begin : g_tap0
      assign ref_px = r_pix;
    end else begin : g_tapn
      assign ref_px = rdly_q[i];
    end

    assign srch_px = s_pix[8*i +: 8];
    assign diff    = (ref_px >= srch_px) ? (ref_px - srch_px) : (srch_px - ref_px);
    assign add     = {1'b0, acc_q} + {1'b0, diff};
    // Offset wraps for t < i, which lands well above any legal NPIX and reads as inactive.
    assign offs    = t_q - 8'(i);
    assign active  = (state_q == RUN) && (offs < NPIX8);
    assign sum     = (offs == 8'd0) ? diff : (add[8] ? 8'hFF : add[7:0]);
    assign fin[i]  = active && (offs == NPIX8 - 8'd1);

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        acc_q <= '0;
        res_q <= '0;
      end else if (active) begin
        acc_q <= sum;
        if (fin[i]) res_q <= sum;
      end
    end

    assign peout[8*i +: 8] = res_q;
  end

  always_comb begin
    vx_d = '0;
    for (int i = 0; i < NPE; i++) begin
      if (fin[i]) vx_d = 4'(i);
    end
  end

  // Completion strobes are registered so ready, vector and lane data appear together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      peready_q <= '0;
      vx_q      <= '0;
      vy_q      <= '0;
    end else begin
      peready_q <= fin;
      vx_q      <= vx_d;
      if (|fin) vy_q <= pass_q;
    end
  end

  assign peready   = peready_q;
  assign vectorx   = vx_q;
  assign vectory   = vy_q;
  assign busy      = (state_q == RUN);
  assign compstart = busy;
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_sad_pe_array.sv
// Self-checking bench for sad_pe_array: table of pixel patterns with hand-computed lane SADs,
// plus a hand-written mid-run reset sequence.
module tb_sad_pe_array;

  localparam int NPIX   = 16;
  localparam int NPASS  = 16;
  localparam int PLEN   = NPIX + 16;
  localparam int RUNLEN = NPASS * PLEN;
  localparam int NVEC   = 6;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [7:0]   r_pix;
  logic [127:0] s_pix;
  logic [127:0] peout;
  logic [15:0]  peready;
  logic [3:0]   vectorx;
  logic [3:0]   vectory;
  logic         compstart;
  logic         busy;
  logic         done;

  int numChecks = 0;
  int numFails  = 0;

  always #5 clock = ~clock;

  sad_pe_array #(.NPIX(NPIX), .NPASS(NPASS)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .r_pix    (r_pix),
    .s_pix    (s_pix),
    .peout    (peout),
    .peready  (peready),
    .vectorx  (vectorx),
    .vectory  (vectory),
    .compstart(compstart),
    .busy     (busy),
    .done     (done)
  );

  // Reference pixel k = rBase + rStep*k; search pixel for lane i = ref + sOff + sLaneStep*i (mod 256).
  typedef struct {
    string        name;
    int           rBase;
    int           rStep;
    int           sOff;
    int           sLaneStep;
    bit           restart;
    logic [127:0] expLanes;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] refPix(input int idx, input int k);
    if (k >= 0 && k < NPIX) return 8'((vecs[idx].rBase + vecs[idx].rStep * k) & 255);
    return 8'h77;
  endfunction

  function automatic logic [7:0] searchPix(input int idx, input int lane, input int t);
    int k;
    k = t - lane;
    if (k >= 0 && k < NPIX)
      return 8'((int'(refPix(idx, k)) + vecs[idx].sOff + vecs[idx].sLaneStep * lane) & 255);
    return 8'h5A;
  endfunction

  task automatic driveCycle(input int idx, input int t);
    r_pix = refPix(idx, t);
    for (int i = 0; i < 16; i++) s_pix[8*i +: 8] = searchPix(idx, i, t);
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, " peready"}, 128'(peready), 128'h0);
    checkOutput({tag, " peout"}, peout, 128'h0);
    checkOutput({tag, " vectorx"}, 128'(vectorx), 128'h0);
    checkOutput({tag, " vectory"}, 128'(vectory), 128'h0);
    checkOutput({tag, " busy"}, 128'(busy), 128'h0);
    checkOutput({tag, " compstart"}, 128'(compstart), 128'h0);
    checkOutput({tag, " done"}, 128'(done), 128'h0);
  endtask

  // Full operation for one table entry; called at a negedge, returns at a negedge.
  task automatic applyStimulus(input int idx);
    int          t, p, lane, bestDist, expMin;
    logic [15:0] expRdy;
    string       nm;
    bestDist = 256;
    expMin   = 256;
    for (int i = 0; i < 16; i++)
      if (int'(vecs[idx].expLanes[8*i +: 8]) < expMin) expMin = int'(vecs[idx].expLanes[8*i +: 8]);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int c = 0; c < RUNLEN; c++) begin
      t  = c % PLEN;
      p  = c / PLEN;
      nm = $sformatf("%s c%0d", vecs[idx].name, c);
      expRdy = (t >= NPIX) ? (16'h1 << (t - NPIX)) : 16'h0;
      checkOutput({nm, " peready"}, 128'(peready), 128'(expRdy));
      checkOutput({nm, " onehot"}, 128'($countones(peready) <= 1), 128'h1);
      checkOutput({nm, " busy"}, 128'(busy), 128'h1);
      checkOutput({nm, " compstart"}, 128'(compstart), 128'(busy));
      checkOutput({nm, " done"}, 128'(done), 128'h0);
      if (t >= NPIX) begin
        lane = t - NPIX;
        checkOutput({nm, " vectorx"}, 128'(vectorx), 128'(lane));
        checkOutput({nm, " vectory"}, 128'(vectory), 128'(p));
        checkOutput({nm, " lane"}, 128'(peout[8*lane +: 8]), 128'(vecs[idx].expLanes[8*lane +: 8]));
      end else begin
        checkOutput({nm, " vectorx"}, 128'(vectorx), 128'h0);
      end
      if (peready != 16'h0 && int'(peout[8*vectorx +: 8]) < bestDist)
        bestDist = int'(peout[8*vectorx +: 8]);
      driveCycle(idx, t);
      start = (vecs[idx].restart && c == 5);
      @(negedge clock);
    end
    start = 1'b0;
    nm = vecs[idx].name;
    checkOutput({nm, " done pulse"}, 128'(done), 128'h1);
    checkOutput({nm, " busy at done"}, 128'(busy), 128'h0);
    checkOutput({nm, " compstart at done"}, 128'(compstart), 128'h0);
    checkOutput({nm, " peready at done"}, 128'(peready), 128'h0);
    @(negedge clock);
    checkOutput({nm, " done width"}, 128'(done), 128'h0);
    checkOutput({nm, " busy idle"}, 128'(busy), 128'h0);
    checkOutput({nm, " bestdist"}, 128'(bestDist), 128'(expMin));
  endtask

  initial begin
    vecs[0] = '{"zero", 'h55, 0, 0, 0, 1'b0, 128'h0};
    vecs[1] = '{"constdiff", 10, 0, 0, 1, 1'b1, 128'hF0E0D0C0B0A090807060504030201000};
    vecs[2] = '{"saturate", 200, 0, -200, 0, 1'b0, {16{8'hFF}}};
    vecs[3] = '{"partialsat", 0, 0, 0, 17, 1'b0, {{15{8'hFF}}, 8'h00}};
    vecs[4] = '{"vshape", 3, 0, -3, 1, 1'b0, 128'hC0B0A090807060504030201000102030};
    vecs[5] = '{"ramp", 0, 3, 0, 1, 1'b0, 128'hF0E0D0C0B0A090807060504030201000};

    reset = 1'b1;
    start = 1'b0;
    r_pix = '0;
    s_pix = '0;
    #12;
    checkIdleZero("reset");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkIdleZero("post-reset");

    for (int v = 0; v < NVEC; v++) applyStimulus(v);

    // Abort at pass 3, t=20 (cycle 116) while PE4's candidate is being presented.
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int c = 0; c < 116; c++) begin
      driveCycle(1, c % PLEN);
      @(negedge clock);
    end
    checkOutput("abort pre peready", 128'(peready), 128'h0010);
    checkOutput("abort pre vectory", 128'(vectory), 128'h3);
    #2 reset = 1'b1;
    #1;
    checkIdleZero("abort async");
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checkOutput($sformatf("abort idle c%0d busy", c), 128'(busy), 128'h0);
      checkOutput($sformatf("abort idle c%0d done", c), 128'(done), 128'h0);
    end
    applyStimulus(1);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
